lamp_dimmer_bank: RTL

//   Parametrised N-channel lamp PWM driver that sits between the traffic FSM and the lamp pins.

---
 rtl/lamp_pkg.sv | 20 ++
 rtl/lamp_pwm_channel.sv | 63 ++++++
 rtl/lamp_dimmer_bank.sv | 105 ++++++++++
 3 files changed

// File: rtl/lamp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lamp_pkg: mode encodings and level clamp helper for lamp_dimmer_bank|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package lamp_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL      = 2'd0,
    MODE_DIM         = 2'd1,
    MODE_NIGHT_BLINK = 2'd2,
    MODE_RESERVED    = 2'd3
  } mode_e;

  function automatic int unsigned clamp_level(input int unsigned val, input int unsigned maxl);
    return (val > maxl) ? maxl : val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lamp_pwm_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lamp_pwm_channel: level register with boundary-only ramping and a   |
// | registered PWM compare. Revision: 1.0                               |
// +--------------------------------------------------------------------+
module lamp_pwm_channel #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_stb,
  input  logic [PWM_BITS-1:0] i_cnt,
  input  logic [PWM_BITS-1:0] i_target,
  output logic [PWM_BITS-1:0] o_level,
  output logic                o_pwm
);

  localparam int c_MAXL   = (1 << PWM_BITS) - 1;
  // A step of MAXL or more always lands on the target, so saturate it to fit the datapath.
  localparam int c_STEP_I = (RAMP_STEP > c_MAXL) ? c_MAXL : RAMP_STEP;
  localparam logic [PWM_BITS:0] c_STEP = (PWM_BITS+1)'(c_STEP_I);

  logic [PWM_BITS-1:0] r_level;
  logic                r_pwm;
  logic [PWM_BITS-1:0] w_level_nxt;
  logic [PWM_BITS:0]   w_lvl_x;
  logic [PWM_BITS:0]   w_tgt_x;
  logic [PWM_BITS:0]   w_up;
  logic [PWM_BITS:0]   w_tgt_plus;

  always_comb begin
    w_lvl_x     = {1'b0, r_level};
    w_tgt_x     = {1'b0, i_target};
    w_up        = w_lvl_x + c_STEP;
    w_tgt_plus  = w_tgt_x + c_STEP;
    w_level_nxt = r_level;
    if (c_STEP == '0) begin
      w_level_nxt = i_target;
    end else if (r_level < i_target) begin
      w_level_nxt = (w_up >= w_tgt_x) ? i_target : w_up[PWM_BITS-1:0];
    end else if (r_level > i_target) begin
      w_level_nxt = (w_lvl_x <= w_tgt_plus) ? i_target : (r_level - c_STEP[PWM_BITS-1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      r_pwm   <= 1'b0;
    end else begin
      if (i_stb) begin
        r_level <= w_level_nxt;
      end
      r_pwm <= (i_cnt < r_level);
    end
  end

  assign o_level = r_level;
  assign o_pwm   = r_pwm;

endmodule
`default_nettype wire

// File: rtl/lamp_dimmer_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lamp_dimmer_bank: N-channel ramping lamp PWM driver with DIM and    |
// | NIGHT_BLINK modes. Revision: 1.0                                    |
// +--------------------------------------------------------------------+
module lamp_dimmer_bank
  import lamp_pkg::*;
#(
  parameter int NUM_CH        = 6,
  parameter int PWM_BITS      = 8,
  parameter int RAMP_STEP     = 16,
  parameter int BLINK_PERIODS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   i_lamp_on,
  input  logic [1:0]          i_mode,
  input  logic [PWM_BITS-1:0] i_dim_level,
  input  logic [NUM_CH-1:0]   i_blink_mask,
  output logic [NUM_CH-1:0]   o_lamp_pwm,
  output logic                o_period_stb,
  output logic                o_busy
);

  localparam int c_MAXL = (1 << PWM_BITS) - 1;
  localparam logic [PWM_BITS-1:0] c_MAXL_V = PWM_BITS'(c_MAXL);
  localparam logic [PWM_BITS-1:0] c_LAST   = PWM_BITS'(c_MAXL - 1);
  localparam int c_BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [c_BW-1:0] c_BLAST = c_BW'(BLINK_PERIODS - 1);

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] w_cnt_nxt;
  logic                r_stb;
  logic [c_BW-1:0]     r_bcnt;
  logic                r_bph;
  logic [PWM_BITS-1:0] w_dim;
  logic [NUM_CH-1:0]   w_ch_busy;
  mode_e               w_mode;

  assign w_mode    = mode_e'(i_mode);
  assign w_cnt_nxt = (r_cnt == c_LAST) ? '0 : (r_cnt + 1'b1);
  assign w_dim     = PWM_BITS'(clamp_level(32'(i_dim_level), 32'(c_MAXL)));

  // The strobe is decoded from the next count so it is a flop aligned with the wrap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_stb <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_stb <= (w_cnt_nxt == c_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt <= '0;
      r_bph  <= 1'b0;
    end else if (w_mode != MODE_NIGHT_BLINK) begin
      r_bcnt <= '0;
      r_bph  <= 1'b0;
    end else if (r_stb) begin
      if (r_bcnt == c_BLAST) begin
        r_bcnt <= '0;
        r_bph  <= ~r_bph;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [PWM_BITS-1:0] w_tgt;
    logic [PWM_BITS-1:0] w_lvl;

    always_comb begin
      w_tgt = '0;
      case (w_mode)
        MODE_DIM:         w_tgt = i_lamp_on[gi] ? w_dim : '0;
        MODE_NIGHT_BLINK: w_tgt = (i_blink_mask[gi] & r_bph) ? c_MAXL_V : '0;
        default:          w_tgt = i_lamp_on[gi] ? c_MAXL_V : '0;
      endcase
    end

    lamp_pwm_channel #(
      .PWM_BITS  (PWM_BITS),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_stb    (r_stb),
      .i_cnt    (r_cnt),
      .i_target (w_tgt),
      .o_level  (w_lvl),
      .o_pwm    (o_lamp_pwm[gi])
    );

    assign w_ch_busy[gi] = (w_lvl != w_tgt);
  end

  assign o_period_stb = r_stb;
  assign o_busy       = |w_ch_busy;

endmodule
`default_nettype wire
